// File: rtl/memory_stage.sv
// RV64 MEM stage: runs loads/stores on a req/ack data port, stalls execute while an access is
// in flight, and registers the result bundle toward writeback.
module memory_stage #(
  parameter int XLEN    = 64,
  parameter int TIMEOUT = 255
) (
  input  logic            clk,
  input  logic            RESET_N,
  input  logic            MEM_V,
  input  logic [31:0]     MEM_IR,
  input  logic [XLEN-1:0] MEM_NPC,
  input  logic [XLEN-1:0] MEM_ALU_RESULT,
  input  logic [XLEN-1:0] MEM_SR2,
  input  logic [XLEN-1:0] MEM_CSRFD,
  input  logic [XLEN-1:0] MEM_RFD,
  input  logic            MEM_ECALL,
  output logic            MEM_STALL,
  output logic            DMEM_REQ,
  output logic            DMEM_WE,
  output logic [XLEN-1:0] DMEM_ADDR,
  output logic [XLEN-1:0] DMEM_WDATA,
  output logic [7:0]      DMEM_WSTRB,
  input  logic            DMEM_ACK,
  input  logic [XLEN-1:0] DMEM_RDATA,
  output logic            WB_V,
  output logic [31:0]     WB_IR,
  output logic [XLEN-1:0] WB_NPC,
  output logic [XLEN-1:0] WB_CSRFD,
  output logic [XLEN-1:0] WB_RFD,
  output logic            WB_ECALL,
  output logic [XLEN-1:0] WB_RESULT,
  output logic [1:0]      WB_EXC
);

  localparam logic [6:0] OPC_LOAD     = 7'b0000011;
  localparam logic [6:0] OPC_STORE    = 7'b0100011;
  localparam logic [1:0] EXC_NONE     = 2'd0;
  localparam logic [1:0] EXC_MISALIGN = 2'd1;
  localparam logic [1:0] EXC_TIMEOUT  = 2'd2;
  localparam logic [7:0] TIMEOUT_C    = 8'(TIMEOUT);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_DONE = 2'd2
  } state_e;

  state_e          state_q;
  logic [7:0]      cnt_q;
  logic [1:0]      exc_q;
  logic [XLEN-1:0] rdata_q;
  logic            dmem_req_q;
  logic            dmem_we_q;
  logic [XLEN-1:0] dmem_addr_q;
  logic [XLEN-1:0] dmem_wdata_q;
  logic [7:0]      dmem_wstrb_q;
  logic            wb_v_q;
  logic [31:0]     wb_ir_q;
  logic [XLEN-1:0] wb_npc_q;
  logic [XLEN-1:0] wb_csrfd_q;
  logic [XLEN-1:0] wb_rfd_q;
  logic            wb_ecall_q;
  logic [XLEN-1:0] wb_result_q;
  logic [1:0]      wb_exc_q;

  logic [6:0]      opcode_s;
  logic [2:0]      funct3_s;
  logic [2:0]      lane_s;
  logic            is_load_s;
  logic            is_store_s;
  logic            mem_op_s;
  logic [1:0]      size_s;
  logic            misaligned_s;
  logic [7:0]      cnt_inc_s;
  logic [XLEN-1:0] rdata_shift_s;
  logic [XLEN-1:0] wdata_d;
  logic [7:0]      wstrb_d;
  logic [XLEN-1:0] load_ext_d;
  logic [XLEN-1:0] done_result_d;

  assign opcode_s   = MEM_IR[6:0];
  assign funct3_s   = MEM_IR[14:12];
  assign lane_s     = MEM_ALU_RESULT[2:0];
  assign is_load_s  = (opcode_s == OPC_LOAD);
  assign is_store_s = (opcode_s == OPC_STORE);
  assign mem_op_s   = MEM_V & (is_load_s | is_store_s);
  assign cnt_inc_s  = cnt_q + 8'd1;

  // Gated by reset so the stall drops with every other output while RESET_N is low.
  assign MEM_STALL = RESET_N & mem_op_s & (state_q != S_DONE);

  // Access size (0=B,1=H,2=W,3=D) and alignment check; undefined store widths act as SD.
  always_comb begin
    if (is_store_s && funct3_s[2]) begin
      size_s = 2'b11;
    end else begin
      size_s = funct3_s[1:0];
    end
    case (size_s)
      2'b00:   misaligned_s = 1'b0;
      2'b01:   misaligned_s = lane_s[0];
      2'b10:   misaligned_s = |lane_s[1:0];
      default: misaligned_s = |lane_s;
    endcase
  end

  // Store data replicated across lanes, byte enables shifted to the addressed lane.
  always_comb begin
    wdata_d = MEM_SR2;
    wstrb_d = 8'hFF;
    case (size_s)
      2'b00: begin
        wdata_d = {8{MEM_SR2[7:0]}};
        wstrb_d = 8'h01 << lane_s;
      end
      2'b01: begin
        wdata_d = {4{MEM_SR2[15:0]}};
        wstrb_d = 8'h03 << lane_s;
      end
      2'b10: begin
        wdata_d = {2{MEM_SR2[31:0]}};
        wstrb_d = 8'h0F << lane_s;
      end
      default: begin
        wdata_d = MEM_SR2;
        wstrb_d = 8'hFF;
      end
    endcase
  end

  // Load data: shift the addressed lane down to bit 0, then sign/zero extend.
  always_comb begin
    rdata_shift_s = DMEM_RDATA >> {lane_s, 3'b000};
    case (funct3_s)
      3'b000:  load_ext_d = {{56{rdata_shift_s[7]}},  rdata_shift_s[7:0]};
      3'b001:  load_ext_d = {{48{rdata_shift_s[15]}}, rdata_shift_s[15:0]};
      3'b010:  load_ext_d = {{32{rdata_shift_s[31]}}, rdata_shift_s[31:0]};
      3'b100:  load_ext_d = {56'd0, rdata_shift_s[7:0]};
      3'b101:  load_ext_d = {48'd0, rdata_shift_s[15:0]};
      3'b110:  load_ext_d = {32'd0, rdata_shift_s[31:0]};
      default: load_ext_d = DMEM_RDATA;
    endcase
  end

  // Result written back when a memory op completes.
  always_comb begin
    if (is_store_s) begin
      done_result_d = MEM_ALU_RESULT;
    end else if (exc_q != EXC_NONE) begin
      done_result_d = '0;
    end else begin
      done_result_d = rdata_q;
    end
  end

  // Access FSM with registered DMEM request and writeback bundle.
  always_ff @(posedge clk or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q      <= S_IDLE;
      cnt_q        <= 8'd0;
      exc_q        <= EXC_NONE;
      rdata_q      <= '0;
      dmem_req_q   <= 1'b0;
      dmem_we_q    <= 1'b0;
      dmem_addr_q  <= '0;
      dmem_wdata_q <= '0;
      dmem_wstrb_q <= 8'd0;
      wb_v_q       <= 1'b0;
      wb_ir_q      <= 32'd0;
      wb_npc_q     <= '0;
      wb_csrfd_q   <= '0;
      wb_rfd_q     <= '0;
      wb_ecall_q   <= 1'b0;
      wb_result_q  <= '0;
      wb_exc_q     <= EXC_NONE;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (!mem_op_s) begin
            wb_v_q      <= MEM_V;
            wb_ir_q     <= MEM_IR;
            wb_npc_q    <= MEM_NPC;
            wb_csrfd_q  <= MEM_CSRFD;
            wb_rfd_q    <= MEM_RFD;
            wb_ecall_q  <= MEM_ECALL;
            wb_result_q <= MEM_ALU_RESULT;
            wb_exc_q    <= EXC_NONE;
          end else if (misaligned_s) begin
            wb_v_q  <= 1'b0;
            exc_q   <= EXC_MISALIGN;
            state_q <= S_DONE;
          end else begin
            // Writeback sees a bubble until the access completes.
            wb_v_q       <= 1'b0;
            dmem_req_q   <= 1'b1;
            dmem_we_q    <= is_store_s;
            dmem_addr_q  <= {MEM_ALU_RESULT[XLEN-1:3], 3'b000};
            dmem_wdata_q <= wdata_d;
            dmem_wstrb_q <= wstrb_d;
            cnt_q        <= 8'd0;
            exc_q        <= EXC_NONE;
            state_q      <= S_REQ;
          end
        end
        S_REQ: begin
          cnt_q <= cnt_inc_s;
          // An ACK on the timeout edge still completes the access normally.
          if (DMEM_ACK) begin
            dmem_req_q <= 1'b0;
            rdata_q    <= load_ext_d;
            state_q    <= S_DONE;
          end else if (cnt_inc_s == TIMEOUT_C) begin
            dmem_req_q <= 1'b0;
            exc_q      <= EXC_TIMEOUT;
            state_q    <= S_DONE;
          end
        end
        S_DONE: begin
          wb_v_q      <= MEM_V;
          wb_ir_q     <= MEM_IR;
          wb_npc_q    <= MEM_NPC;
          wb_csrfd_q  <= MEM_CSRFD;
          wb_rfd_q    <= MEM_RFD;
          wb_ecall_q  <= MEM_ECALL;
          wb_result_q <= done_result_d;
          wb_exc_q    <= exc_q;
          exc_q       <= EXC_NONE;
          cnt_q       <= 8'd0;
          state_q     <= S_IDLE;
        end
        default: begin
          state_q    <= S_IDLE;
          dmem_req_q <= 1'b0;
        end
      endcase
    end
  end

  assign DMEM_REQ   = dmem_req_q;
  assign DMEM_WE    = dmem_we_q;
  assign DMEM_ADDR  = dmem_addr_q;
  assign DMEM_WDATA = dmem_wdata_q;
  assign DMEM_WSTRB = dmem_wstrb_q;
  assign WB_V       = wb_v_q;
  assign WB_IR      = wb_ir_q;
  assign WB_NPC     = wb_npc_q;
  assign WB_CSRFD   = wb_csrfd_q;
  assign WB_RFD     = wb_rfd_q;
  assign WB_ECALL   = wb_ecall_q;
  assign WB_RESULT  = wb_result_q;
  assign WB_EXC     = wb_exc_q;

endmodule

// File: tb/tb_memory_stage.sv
// Directed bench for memory_stage: pass-through, load extension, store lanes, misalignment,
// timeout with and without a last-cycle ACK, and asynchronous reset mid-access.
module tb_memory_stage;
  logic        clk = 1'b0;
  logic        RESET_N;
  logic        MEM_V;
  logic [31:0] MEM_IR;
  logic [63:0] MEM_NPC;
  logic [63:0] MEM_ALU_RESULT;
  logic [63:0] MEM_SR2;
  logic [63:0] MEM_CSRFD;
  logic [63:0] MEM_RFD;
  logic        MEM_ECALL;
  logic        MEM_STALL;
  logic        DMEM_REQ;
  logic        DMEM_WE;
  logic [63:0] DMEM_ADDR;
  logic [63:0] DMEM_WDATA;
  logic [7:0]  DMEM_WSTRB;
  logic        DMEM_ACK;
  logic [63:0] DMEM_RDATA;
  logic        WB_V;
  logic [31:0] WB_IR;
  logic [63:0] WB_NPC;
  logic [63:0] WB_CSRFD;
  logic [63:0] WB_RFD;
  logic        WB_ECALL;
  logic [63:0] WB_RESULT;
  logic [1:0]  WB_EXC;

  int checks = 0;
  int errors = 0;
  int req_high = 0;

  always #5 clk = ~clk;

  memory_stage dut (
    .clk(clk), .RESET_N(RESET_N),
    .MEM_V(MEM_V), .MEM_IR(MEM_IR), .MEM_NPC(MEM_NPC), .MEM_ALU_RESULT(MEM_ALU_RESULT),
    .MEM_SR2(MEM_SR2), .MEM_CSRFD(MEM_CSRFD), .MEM_RFD(MEM_RFD), .MEM_ECALL(MEM_ECALL),
    .MEM_STALL(MEM_STALL),
    .DMEM_REQ(DMEM_REQ), .DMEM_WE(DMEM_WE), .DMEM_ADDR(DMEM_ADDR), .DMEM_WDATA(DMEM_WDATA),
    .DMEM_WSTRB(DMEM_WSTRB), .DMEM_ACK(DMEM_ACK), .DMEM_RDATA(DMEM_RDATA),
    .WB_V(WB_V), .WB_IR(WB_IR), .WB_NPC(WB_NPC), .WB_CSRFD(WB_CSRFD), .WB_RFD(WB_RFD),
    .WB_ECALL(WB_ECALL), .WB_RESULT(WB_RESULT), .WB_EXC(WB_EXC)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic drive(input logic [31:0] ir, input logic [63:0] addr, input logic [63:0] sr2);
    MEM_V          = 1'b1;
    MEM_IR         = ir;
    MEM_ALU_RESULT = addr;
    MEM_SR2        = sr2;
    MEM_NPC        = addr + 64'd4;
  endtask

  initial begin
    RESET_N = 1'b0; MEM_V = 1'b0; MEM_IR = 32'd0; MEM_NPC = 64'd0; MEM_ALU_RESULT = 64'd0;
    MEM_SR2 = 64'd0; MEM_CSRFD = 64'd0; MEM_RFD = 64'd0; MEM_ECALL = 1'b0;
    DMEM_ACK = 1'b0; DMEM_RDATA = 64'd0;
    repeat (2) @(negedge clk);
    chk("rst_req", 64'(DMEM_REQ), 64'd0);
    chk("rst_stall", 64'(MEM_STALL), 64'd0);
    chk("rst_wb_v", 64'(WB_V), 64'd0);
    chk("rst_wb_result", WB_RESULT, 64'd0);
    chk("rst_wb_exc", 64'(WB_EXC), 64'd0);
    RESET_N = 1'b1;

    // ADD passes through in one cycle
    MEM_V = 1'b1; MEM_IR = 32'h0000_0033; MEM_ALU_RESULT = 64'h1234; MEM_NPC = 64'h104;
    MEM_CSRFD = 64'hAA; MEM_RFD = 64'hBB; MEM_ECALL = 1'b1;
    #1 chk("add_stall", 64'(MEM_STALL), 64'd0);
    tick();
    chk("add_wb_v", 64'(WB_V), 64'd1);
    chk("add_wb_result", WB_RESULT, 64'h1234);
    chk("add_wb_npc", WB_NPC, 64'h104);
    chk("add_wb_ir", 64'(WB_IR), 64'h33);
    chk("add_wb_csrfd", WB_CSRFD, 64'hAA);
    chk("add_wb_rfd", WB_RFD, 64'hBB);
    chk("add_wb_ecall", 64'(WB_ECALL), 64'd1);
    chk("add_req", 64'(DMEM_REQ), 64'd0);
    chk("add_stall2", 64'(MEM_STALL), 64'd0);
    MEM_V = 1'b0; MEM_ECALL = 1'b0;
    tick();
    chk("bubble_wb_v", 64'(WB_V), 64'd0);

    // LB at 0x1003, ACK in second REQ cycle
    drive(32'h0000_0003, 64'h1003, 64'd0);
    #1 chk("lb_stall_idle", 64'(MEM_STALL), 64'd1);
    tick();
    chk("lb_req", 64'(DMEM_REQ), 64'd1);
    chk("lb_addr", DMEM_ADDR, 64'h1000);
    chk("lb_we", 64'(DMEM_WE), 64'd0);
    chk("lb_stall_req", 64'(MEM_STALL), 64'd1);
    tick();
    chk("lb_req_wait", 64'(DMEM_REQ), 64'd1);
    DMEM_ACK = 1'b1; DMEM_RDATA = 64'h0000_0000_8000_0000;
    tick();
    DMEM_ACK = 1'b0;
    #1 chk("lb_req_done", 64'(DMEM_REQ), 64'd0);
    chk("lb_stall_done", 64'(MEM_STALL), 64'd0);
    tick();
    chk("lb_result", WB_RESULT, 64'hFFFF_FFFF_FFFF_FF80);
    chk("lb_exc", 64'(WB_EXC), 64'd0);
    chk("lb_wb_v", 64'(WB_V), 64'd1);

    // LBU same access
    drive(32'h0000_4003, 64'h1003, 64'd0);
    tick();
    tick();
    DMEM_ACK = 1'b1;
    tick();
    DMEM_ACK = 1'b0;
    tick();
    chk("lbu_result", WB_RESULT, 64'h80);

    // SH at 0x2006
    drive(32'h0000_1023, 64'h2006, 64'hBEEF);
    tick();
    chk("sh_req", 64'(DMEM_REQ), 64'd1);
    chk("sh_we", 64'(DMEM_WE), 64'd1);
    chk("sh_addr", DMEM_ADDR, 64'h2000);
    chk("sh_wstrb", 64'(DMEM_WSTRB), 64'hC0);
    chk("sh_wdata", DMEM_WDATA, 64'hBEEF_BEEF_BEEF_BEEF);
    chk("sh_stall", 64'(MEM_STALL), 64'd1);
    DMEM_ACK = 1'b1;
    tick();
    DMEM_ACK = 1'b0;
    #1 chk("sh_stall_done", 64'(MEM_STALL), 64'd0);
    tick();
    chk("sh_result", WB_RESULT, 64'h2006);
    chk("sh_exc", 64'(WB_EXC), 64'd0);

    // LW misaligned at 0x3002
    drive(32'h0000_2003, 64'h3002, 64'd0);
    #1 chk("lw_mis_stall", 64'(MEM_STALL), 64'd1);
    tick();
    chk("lw_mis_req", 64'(DMEM_REQ), 64'd0);
    chk("lw_mis_stall_done", 64'(MEM_STALL), 64'd0);
    tick();
    chk("lw_mis_exc", 64'(WB_EXC), 64'd1);
    chk("lw_mis_result", WB_RESULT, 64'd0);
    chk("lw_mis_wb_v", 64'(WB_V), 64'd1);

    // LD with ACK withheld: request held 255 REQ cycles then aborted
    drive(32'h0000_3003, 64'h4000, 64'd0);
    tick();
    chk("ld_to_req", 64'(DMEM_REQ), 64'd1);
    req_high = 0;
    repeat (254) begin
      tick();
      if (DMEM_REQ) req_high++;
    end
    chk("ld_to_held", 64'(req_high), 64'd254);
    tick();
    chk("ld_to_req_drop", 64'(DMEM_REQ), 64'd0);
    chk("ld_to_stall", 64'(MEM_STALL), 64'd0);
    tick();
    chk("ld_to_exc", 64'(WB_EXC), 64'd2);
    chk("ld_to_result", WB_RESULT, 64'd0);

    // LD with ACK on the 255th REQ cycle: ACK wins
    drive(32'h0000_3003, 64'h4008, 64'd0);
    tick();
    repeat (254) tick();
    chk("ld_late_req", 64'(DMEM_REQ), 64'd1);
    DMEM_ACK = 1'b1; DMEM_RDATA = 64'h0123_4567_89AB_CDEF;
    tick();
    DMEM_ACK = 1'b0;
    tick();
    chk("ld_late_exc", 64'(WB_EXC), 64'd0);
    chk("ld_late_result", WB_RESULT, 64'h0123_4567_89AB_CDEF);

    // Asynchronous reset mid-REQ, then a fresh load
    drive(32'h0000_3003, 64'h5000, 64'd0);
    tick();
    chk("rst_mid_req_before", 64'(DMEM_REQ), 64'd1);
    #2 RESET_N = 1'b0;
    #1 chk("rst_mid_req", 64'(DMEM_REQ), 64'd0);
    chk("rst_mid_stall", 64'(MEM_STALL), 64'd0);
    chk("rst_mid_wb_v", 64'(WB_V), 64'd0);
    chk("rst_mid_wb_result", WB_RESULT, 64'd0);
    @(negedge clk);
    RESET_N = 1'b1;
    tick();
    chk("post_rst_req", 64'(DMEM_REQ), 64'd1);
    chk("post_rst_addr", DMEM_ADDR, 64'h5000);
    DMEM_ACK = 1'b1; DMEM_RDATA = 64'hFEDC_BA98_7654_3210;
    tick();
    DMEM_ACK = 1'b0;
    tick();
    chk("post_rst_result", WB_RESULT, 64'hFEDC_BA98_7654_3210);
    chk("post_rst_exc", 64'(WB_EXC), 64'd0);
    MEM_V = 1'b0;
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
